// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/exception addresses, NOP word and next-PC select codes.
package mips_pkg;

  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC
  } pc_sel_e;

  // Word offset is sign-extended and scaled to bytes; wraps modulo 2^32.
  function automatic logic [31:0] br_target(input logic [31:0] base, input logic [15:0] imm);
    return base + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, decode redirect inputs and IF/ID outputs.
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_base;
  logic [15:0] br_imm;
  logic        j_en;
  logic [25:0] j_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        exc_misalign;
  logic [31:0] bad_vaddr;

  modport master (
    output imem_addr, if_id_valid, if_id_instr, if_id_pc4, exc_misalign, bad_vaddr,
    input  imem_rdata, stall, br_taken, br_base, br_imm, j_en, j_index, jr_en, jr_target,
           exc_req
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_instr, if_id_pc4, exc_misalign, bad_vaddr,
    output imem_rdata, stall, br_taken, br_base, br_imm, j_en, j_index, jr_en, jr_target,
           exc_req
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority select (exc > jr > j > br > seq) with target arithmetic and JR alignment check.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] seq_pc_i,
  input  logic        exc_req_i,
  input  logic        jr_en_i,
  input  logic        j_en_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_base_i,
  input  logic [15:0] br_imm_i,
  input  logic [25:0] j_index_i,
  input  logic [31:0] jr_target_i,
  output pc_sel_e     sel_o,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    sel_o      = SEL_SEQ;
    next_pc_o  = seq_pc_i;
    misalign_o = 1'b0;
    if (exc_req_i) begin
      sel_o     = SEL_EXC;
      next_pc_o = EXC_VECTOR;
    end else if (jr_en_i) begin
      sel_o = SEL_JR;
      if (|jr_target_i[1:0]) begin
        next_pc_o  = EXC_VECTOR;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = jr_target_i;
      end
    end else if (j_en_i) begin
      sel_o     = SEL_J;
      next_pc_o = {br_base_i[31:28], j_index_i, 2'b00};
    end else if (br_taken_i) begin
      sel_o     = SEL_BR;
      next_pc_o = br_target(br_base_i, br_imm_i);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads IF/ID, and traps misaligned register jumps.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d, pc_plus4, next_pc;
  pc_sel_e     sel;
  logic        misalign;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        exc_mis_q, exc_mis_d;
  logic [31:0] bad_q, bad_d;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_pc_next_sel (
    .seq_pc_i   (pc_plus4),
    .exc_req_i  (bus.exc_req),
    .jr_en_i    (bus.jr_en),
    .j_en_i     (bus.j_en),
    .br_taken_i (bus.br_taken),
    .br_base_i  (bus.br_base),
    .br_imm_i   (bus.br_imm),
    .j_index_i  (bus.j_index),
    .jr_target_i(bus.jr_target),
    .sel_o      (sel),
    .next_pc_o  (next_pc),
    .misalign_o (misalign)
  );

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    exc_mis_d = 1'b0;
    bad_d     = bad_q;
    if (bus.exc_req) begin
      pc_d    = next_pc;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
    end else if (!bus.stall) begin
      pc_d      = next_pc;
      exc_mis_d = misalign;
      if (misalign) bad_d = bus.jr_target;
      // The word fetched alongside a redirect is the delay slot.
      if (sel == SEL_SEQ || DELAY_SLOT) begin
        valid_d = 1'b1;
        instr_d = bus.imem_rdata;
        pc4_d   = pc_plus4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_WORD;
        pc4_d   = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= NOP_WORD;
      pc4_q     <= 32'h0;
      exc_mis_q <= 1'b0;
      bad_q     <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      exc_mis_q <= exc_mis_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.exc_misalign = exc_mis_q;
  assign bus.bad_vaddr    = bad_q;

endmodule
